// File: rtl/scfifo_p.sv
// scfifo_p: single-clock FIFO of 2**LOG_DEPTH words with run-time almost flags,
// show-ahead or normal read and optional output register. SCFIFO_P_ERR_FLAGS_EN adds sticky overflow/underflow.
module scfifo_p #(
    parameter int WIDTH           = 20,
    parameter int LOG_DEPTH       = 5,
    parameter int SHOW_AHEAD      = 1,
    parameter int OUTPUT_REGISTER = 1,
    parameter     FAMILY          = "S10"
) (
    input  logic                 clock,
    input  logic                 aclr_n,
    input  logic                 sclr,
    input  logic [WIDTH-1:0]     data,
    input  logic                 wrreq,
    input  logic                 rdreq,
    input  logic [LOG_DEPTH:0]   af_thresh,
    input  logic [LOG_DEPTH:0]   ae_thresh,
    output logic [WIDTH-1:0]     q,
    output logic [LOG_DEPTH:0]   usedw,
    output logic                 empty,
    output logic                 full,
    output logic                 almost_empty,
    output logic                 almost_full
`ifdef SCFIFO_P_ERR_FLAGS_EN
    ,
    output logic                 overflow,
    output logic                 underflow
`endif
);
    localparam int CW = LOG_DEPTH + 1;
    localparam int DEPTH = 2 ** LOG_DEPTH;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // The family string only steers vendor RAM inference; it has no logic of its own.
    logic unused_family;
    assign unused_family = (FAMILY == "S10");

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [LOG_DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        usedw_q, usedw_d, ram_cnt_q, ram_cnt_d;
    logic                 full_q, empty_q, af_q, ae_q, rst_pend_q;
    logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
    logic [WIDTH-1:0]     s1_data_q, s2_data_q;
    logic                 empty_int, acc_wr, acc_rd, fetch, s1_adv, s2_load;

    // Stage 1 is the RAM read register, stage 2 the optional output register;
    // in show-ahead mode they form a small prefetch chain with the head word at the last stage.
    always_comb begin
        empty_int = empty_q;
        if (SHOW_AHEAD != 0) begin
            empty_int = (OUTPUT_REGISTER != 0) ? !s2_v_q : !s1_v_q;
        end
        acc_wr  = wrreq & ~full_q;
        acc_rd  = rdreq & ~empty_int;
        s2_load = (OUTPUT_REGISTER != 0) && s1_v_q &&
                  ((SHOW_AHEAD == 0) || !s2_v_q || acc_rd);
        s1_adv  = 1'b1;
        fetch   = acc_rd;
        if (SHOW_AHEAD != 0) begin
            s1_adv = (OUTPUT_REGISTER != 0) ? s2_load : acc_rd;
            fetch  = (ram_cnt_q != '0) && (!s1_v_q || s1_adv);
        end
        s1_v_d    = fetch | (s1_v_q & ~s1_adv);
        s2_v_d    = s2_load | (s2_v_q & ~acc_rd);
        usedw_d   = usedw_q + CW'(acc_wr) - CW'(acc_rd);
        ram_cnt_d = ram_cnt_q + CW'(acc_wr) - CW'(fetch);
        wr_ptr_d  = wr_ptr_q + LOG_DEPTH'(acc_wr);
        rd_ptr_d  = rd_ptr_q + LOG_DEPTH'(fetch);
    end

    always_ff @(posedge clock) begin
        if (acc_wr && !sclr) begin
            mem[wr_ptr_q] <= data;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            ram_cnt_q  <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= 1'b0;
            ae_q       <= 1'b0;
            rst_pend_q <= 1'b1;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else if (sclr) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            usedw_q    <= '0;
            ram_cnt_q  <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            af_q       <= (af_thresh == '0);
            ae_q       <= (ae_thresh != '0);
            rst_pend_q <= 1'b0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
            s1_data_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            usedw_q    <= usedw_d;
            ram_cnt_q  <= ram_cnt_d;
            full_q     <= (usedw_d == DEPTH_C);
            empty_q    <= (usedw_d == '0);
            af_q       <= (usedw_d >= af_thresh);
            ae_q       <= (usedw_d < ae_thresh);
            rst_pend_q <= 1'b0;
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
            if (fetch) begin
                s1_data_q <= mem[rd_ptr_q];
            end
            if (s2_load) begin
                s2_data_q <= s1_data_q;
            end
        end
    end

`ifdef SCFIFO_P_ERR_FLAGS_EN
    logic ovf_q, unf_q;

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (sclr) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wrreq && full_q) begin
                ovf_q <= 1'b1;
            end
            if (rdreq && empty_int) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`endif

    // Flag registers cannot capture live thresholds asynchronously, so until the
    // first edge after aclr_n the almost flags are derived from the thresholds directly.
    assign almost_full  = rst_pend_q ? (af_thresh == '0) : af_q;
    assign almost_empty = rst_pend_q ? (ae_thresh != '0) : ae_q;
    assign q     = (OUTPUT_REGISTER != 0) ? s2_data_q : s1_data_q;
    assign usedw = usedw_q;
    assign empty = empty_int;
    assign full  = full_q;
endmodule

// File: tb/tb_scfifo_p.sv
// tb_scfifo_p: vector table, directed corner sequences and a randomized soak against
// queue-based reference models for a show-ahead/registered and a normal/unregistered instance.
module tb_scfifo_p;
    localparam int W = 20;
    localparam int LD = 5;
    localparam int DEPTH = 32;
    localparam int RL = 2;

    logic clock = 1'b0;
    logic aclr_n, sclr;
    logic [W-1:0] data, data_n;
    logic wrreq, rdreq, wr_n, rd_n;
    logic [LD:0] af_thresh, ae_thresh;
    logic [W-1:0] q, q_n;
    logic [LD:0] usedw, usedw_n;
    logic empty, full, almost_empty, almost_full;
    logic empty_n, full_n, almost_empty_n, almost_full_n;
`ifdef SCFIFO_P_ERR_FLAGS_EN
    logic overflow, underflow, overflow_n, underflow_n;
`endif

    always #5 clock = ~clock;

    scfifo_p #(.WIDTH(W), .LOG_DEPTH(LD), .SHOW_AHEAD(1), .OUTPUT_REGISTER(1)) u_dut (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .q(q), .usedw(usedw), .empty(empty),
        .full(full), .almost_empty(almost_empty), .almost_full(almost_full)
`ifdef SCFIFO_P_ERR_FLAGS_EN
        , .overflow(overflow), .underflow(underflow)
`endif
    );

    scfifo_p #(.WIDTH(W), .LOG_DEPTH(LD), .SHOW_AHEAD(0), .OUTPUT_REGISTER(0)) u_dut_n (
        .clock(clock), .aclr_n(aclr_n), .sclr(sclr), .data(data_n), .wrreq(wr_n), .rdreq(rd_n),
        .af_thresh(af_thresh), .ae_thresh(ae_thresh), .q(q_n), .usedw(usedw_n), .empty(empty_n),
        .full(full_n), .almost_empty(almost_empty_n), .almost_full(almost_full_n)
`ifdef SCFIFO_P_ERR_FLAGS_EN
        , .overflow(overflow_n), .underflow(underflow_n)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        int wr; int rd; int af; int ae;
        int exp_u; int exp_af; int exp_ae; int chk_q; int exp_q;
    } vec_t;
    vec_t tbl [13];

    logic [W-1:0] mq[$];
    logic [W-1:0] nq[$];
    logic [W-1:0] n_last;
    int stable, af_e, ae_e;
    bit ovf_m, unf_m;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d);
        data = d;
        wrreq = 1'b1;
        tick();
        wrreq = 1'b0;
    endtask

    task automatic clr();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
    endtask

    task automatic pop_expect(input logic [W-1:0] exp, input string nm);
        int n;
        n = 0;
        while (empty && n < 10) begin
            tick();
            n++;
        end
        chk({nm, "_ready"}, empty, 0);
        chk(nm, q, exp);
        rdreq = 1'b1;
        tick();
        rdreq = 1'b0;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        int wp, rp, ph;
        bit acc_w, acc_r, acc_wn, acc_rn;
        int wpct [4] = '{70, 30, 50, 90};
        int rpct [4] = '{30, 70, 50, 90};

        aclr_n = 1'b0; sclr = 1'b0; data = '0; data_n = '0;
        wrreq = 1'b0; rdreq = 1'b0; wr_n = 1'b0; rd_n = 1'b0;
        af_thresh = 6'd30; ae_thresh = 6'd2;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_usedw", usedw, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_q", q, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        chk("rst_empty_n", empty_n, 1);
        chk("rst_q_n", q_n, 0);
        aclr_n = 1'b1;
        tick();

        // wr rd af ae | usedw af ae chk_q q
        tbl[0]  = '{1, 0, 3, 2, 1, 0, 1, 0, 0};
        tbl[1]  = '{1, 0, 3, 2, 2, 0, 0, 0, 0};
        tbl[2]  = '{1, 0, 3, 2, 3, 1, 0, 0, 0};
        tbl[3]  = '{1, 1, 3, 2, 3, 1, 0, 1, 'h102};
        tbl[4]  = '{0, 0, 5, 2, 3, 0, 0, 0, 0};
        tbl[5]  = '{0, 1, 5, 2, 2, 0, 0, 1, 'h103};
        tbl[6]  = '{0, 1, 5, 2, 1, 0, 1, 0, 0};
        tbl[7]  = '{0, 0, 5, 2, 1, 0, 1, 1, 'h104};
        tbl[8]  = '{0, 1, 5, 2, 0, 0, 1, 0, 0};
        tbl[9]  = '{0, 1, 5, 2, 0, 0, 1, 0, 0};
        tbl[10] = '{0, 0, 0, 2, 0, 1, 1, 0, 0};
        tbl[11] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};
        tbl[12] = '{1, 0, 0, 0, 1, 1, 0, 0, 0};
        for (int i = 0; i < 13; i++) begin
            data = W'('h101 + i);
            wrreq = tbl[i].wr[0];
            rdreq = tbl[i].rd[0];
            af_thresh = 6'(tbl[i].af);
            ae_thresh = 6'(tbl[i].ae);
            tick();
            chk($sformatf("tbl%0d_usedw", i), usedw, tbl[i].exp_u);
            chk($sformatf("tbl%0d_af", i), almost_full, tbl[i].exp_af);
            chk($sformatf("tbl%0d_ae", i), almost_empty, tbl[i].exp_ae);
            if (tbl[i].chk_q != 0) chk($sformatf("tbl%0d_q", i), q, tbl[i].exp_q);
        end
        wrreq = 1'b0; rdreq = 1'b0;
        af_thresh = 6'd30; ae_thresh = 6'd2;

        sclr = 1'b1; wrreq = 1'b1;
        tick();
        sclr = 1'b0; wrreq = 1'b0;
        chk("sclr_usedw", usedw, 0);
        chk("sclr_empty", empty, 1);
        chk("sclr_q", q, 0);

        // Show-ahead latency: empty falls RL edges after the write.
        push(W'('h5A));
        chk("lat_e0", empty, 1);
        tick();
        chk("lat_e1", empty, 1);
        tick();
        chk("lat_e2", empty, 0);
        chk("lat_q", q, 'h5A);
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        chk("lat_rd_usedw", usedw, 0);
        chk("lat_rd_empty", empty, 1);

        data_n = W'('h5A); wr_n = 1'b1; tick(); wr_n = 1'b0;
        chk("nlat_empty", empty_n, 0);
        chk("nlat_q_before", q_n, 0);
        rd_n = 1'b1; tick(); rd_n = 1'b0;
        chk("nlat_q", q_n, 'h5A);
        chk("nlat_empty_after", empty_n, 1);
        tick();
        chk("nlat_q_hold", q_n, 'h5A);

        clr();
        tick();
        for (int i = 0; i < 32; i++) begin
            data = W'(i); wrreq = 1'b1;
            tick();
            if (i == 28) chk("fill_af_29", almost_full, 0);
            if (i == 29) chk("fill_af_30", almost_full, 1);
        end
        wrreq = 1'b0;
        chk("fill_full", full, 1);
        chk("fill_usedw", usedw, 32);
        af_thresh = 6'd20;
        data = W'(99); wrreq = 1'b1; tick(); wrreq = 1'b0;
        chk("ovf_usedw", usedw, 32);
        chk("ovf_full", full, 1);
        chk("ovf_af", almost_full, 1);
`ifdef SCFIFO_P_ERR_FLAGS_EN
        chk("ovf_flag", overflow, 1);
`endif
        chk("full_head_q", q, 0);
        data = W'(77); wrreq = 1'b1; rdreq = 1'b1;
        tick();
        wrreq = 1'b0; rdreq = 1'b0;
        chk("full_wr_rd_usedw", usedw, 31);
        chk("full_wr_rd_full", full, 0);
        for (int i = 1; i < 32; i++) begin
            pop_expect(W'(i), "drain");
            if (i == 29) chk("drain_ae_2", almost_empty, 0);
            if (i == 30) chk("drain_ae_1", almost_empty, 1);
        end
        repeat (3) tick();
        chk("drain_empty", empty, 1);
        chk("drain_usedw", usedw, 0);
`ifdef SCFIFO_P_ERR_FLAGS_EN
        chk("unf_before", underflow, 0);
        rdreq = 1'b1; tick(); rdreq = 1'b0;
        chk("unf_flag", underflow, 1);
`endif

        clr();
        for (int i = 0; i < 16; i++) push(W'(i));
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            data = W'(16 + k); wrreq = 1'b1; rdreq = 1'b1;
            tick();
            chk("simul_usedw", usedw, 16);
        end
        wrreq = 1'b0; rdreq = 1'b0;
        for (int i = 4; i < 20; i++) pop_expect(W'(i), "simul_order");

        clr();
        for (int i = 0; i < 7; i++) push(W'(100 + i));
        tick();
        #2;
        aclr_n = 1'b0;
        #1;
        chk("arst_usedw", usedw, 0);
        chk("arst_empty", empty, 1);
        chk("arst_full", full, 0);
        chk("arst_q", q, 0);
        chk("arst_q_n", q_n, 0);
        repeat (3) @(posedge clock);
        #1;
        aclr_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) push(W'(i));
        for (int i = 0; i < 3; i++) pop_expect(W'(i), "arst_order");

        clr();
        mq.delete(); nq.delete();
        n_last = '0; stable = 0; ovf_m = 0; unf_m = 0;
        af_e = int'(af_thresh); ae_e = int'(ae_thresh);
        for (int cyc = 0; cyc < 20000; cyc++) begin
            @(negedge clock);
            chk("soak_usedw", usedw, mq.size());
            chk("soak_full", full, mq.size() == DEPTH);
            chk("soak_af", almost_full, mq.size() >= af_e);
            chk("soak_ae", almost_empty, mq.size() < ae_e);
            if (mq.size() == 0) chk("soak_empty_model0", empty, 1);
            else if (!empty) chk("soak_q", q, mq[0]);
            if (stable >= RL + 1) chk("soak_head_ready", empty, 0);
            chk("soak_n_usedw", usedw_n, nq.size());
            chk("soak_n_empty", empty_n, nq.size() == 0);
            chk("soak_n_full", full_n, nq.size() == DEPTH);
            chk("soak_n_af", almost_full_n, nq.size() >= af_e);
            chk("soak_n_ae", almost_empty_n, nq.size() < ae_e);
            chk("soak_n_q", q_n, n_last);
`ifdef SCFIFO_P_ERR_FLAGS_EN
            chk("soak_ovf", overflow, ovf_m);
            chk("soak_unf", underflow, unf_m);
`endif
            ph = (cyc / 1000) % 4;
            wp = wpct[ph]; rp = rpct[ph];
            wrreq = ($urandom_range(0, 99) < wp);
            rdreq = ($urandom_range(0, 99) < rp);
            data = W'($urandom());
            wr_n = ($urandom_range(0, 99) < wp);
            rd_n = ($urandom_range(0, 99) < rp);
            data_n = W'($urandom());
            if (cyc % 700 == 0) begin
                af_thresh = 6'($urandom_range(0, 33));
                ae_thresh = 6'($urandom_range(0, 33));
            end
            sclr = (cyc == 9000);
            acc_w  = wrreq && mq.size() < DEPTH;
            acc_r  = rdreq && !empty && mq.size() > 0;
            acc_wn = wr_n && nq.size() < DEPTH;
            acc_rn = rd_n && nq.size() > 0;
            if (wrreq && mq.size() == DEPTH) ovf_m = 1;
            if (rdreq && empty) unf_m = 1;
            @(posedge clock);
            if (sclr) begin
                mq.delete(); nq.delete();
                n_last = '0; stable = 0; ovf_m = 0; unf_m = 0;
            end else begin
                if (acc_r) void'(mq.pop_front());
                if (acc_w) mq.push_back(data);
                if (acc_rn) n_last = nq.pop_front();
                if (acc_wn) nq.push_back(data_n);
                if (acc_r) stable = 0;
                else if (mq.size() > 0) stable++;
                else stable = 0;
            end
            af_e = int'(af_thresh); ae_e = int'(ae_thresh);
        end
        @(negedge clock);
        sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0; wr_n = 1'b0; rd_n = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
